// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the async FIFO pointer synchronisers: Gray/binary
// conversion on any width up to MAX_W and the synchroniser depth check.
package fifo_sync_pkg;

  localparam int MAX_W     = 32;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin, input int width);
    logic [MAX_W-1:0] gray;
    logic [MAX_W-1:0] shr;
    shr = {1'b0, bin[MAX_W-1:1]};
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) gray[i] = bin[i] ^ ((i + 1 < width) ? shr[i] : 1'b0);
      else gray[i] = 1'b0;
    end
    return gray;
  endfunction

  // Prefix XOR from the MSB down; bits above width are forced to zero.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray, input int width);
    logic [MAX_W-1:0] bin;
    logic             acc;
    acc = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end else begin
        bin[i] = 1'b0;
      end
    end
    return bin;
  endfunction

  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_MIN) && (n <= SYNC_MAX);
  endfunction

endpackage

// File: rtl/rd_sync_ctrl_if.sv
// Read-domain FIFO control bundle: write-pointer input, read request and
// error clear in; read address, pointers and status out.
interface rd_sync_ctrl_if #(parameter int ADD_SIZE = 8);
  logic [ADD_SIZE:0]   wr_ptr_gray;
  logic                rd_en;
  logic                err_clr;
  logic [ADD_SIZE-1:0] rd_addr;
  logic [ADD_SIZE:0]   rd_ptr_gray;
  logic [ADD_SIZE:0]   wr_ptr_sync;
  logic                rd_empty;
  logic                rd_almost_empty;
  logic [ADD_SIZE:0]   rd_level;
  logic                ovf_err;

  modport master (
    output wr_ptr_gray, rd_en, err_clr,
    input  rd_addr, rd_ptr_gray, wr_ptr_sync, rd_empty, rd_almost_empty, rd_level, ovf_err
  );

  modport slave (
    input  wr_ptr_gray, rd_en, err_clr,
    output rd_addr, rd_ptr_gray, wr_ptr_sync, rd_empty, rd_almost_empty, rd_level, ovf_err
  );
endinterface

// File: rtl/sync_chain.sv
// Generic N-stage, W-bit clock-domain-crossing flop chain with no logic
// between stages; used for both pointer directions.
module sync_chain #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [N];

  // Shift the sampled value one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) stage_r[k] <= {W{1'b0}};
    end else begin
      stage_r[0] <= d;
      for (int k = 1; k < N; k++) stage_r[k] <= stage_r[k-1];
    end
  end

  assign q = stage_r[N-1];

endmodule

// File: rtl/rd_sync_ctrl.sv
// Read-domain FIFO control: synchronises the Gray write pointer, owns the
// read pointer and registers empty / almost-empty / level / overflow status.
module rd_sync_ctrl
  import fifo_sync_pkg::*;
#(
  parameter int ADD_SIZE    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL    = 4
) (
  input  logic           rd_clk,
  input  logic           rd_rst,
  rd_sync_ctrl_if.slave  bus
);

  localparam int             PW      = ADD_SIZE + 1;
  localparam logic [PW-1:0]  DEPTH_L = {1'b1, {ADD_SIZE{1'b0}}};
  localparam logic [PW-1:0]  AE_L    = PW'(AE_LEVEL);

  generate
    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync
      $error("rd_sync_ctrl: SYNC_STAGES must be within 2..4");
    end
  endgenerate

  logic [PW-1:0] wr_gray_sync_s;
  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] rd_bin_next_s;
  logic [PW-1:0] rd_gray_next_s;
  logic [PW-1:0] level_next_s;
  logic          rd_fire_s;
  logic          ovf_set_s;

  logic [PW-1:0] rd_bin_r;
  logic [PW-1:0] rd_gray_r;
  logic [PW-1:0] level_r;
  logic          empty_r;
  logic          ae_r;
  logic          ovf_r;

  sync_chain #(
    .N (SYNC_STAGES),
    .W (PW)
  ) u_wr_sync (
    .clk   (rd_clk),
    .rst_n (rd_rst),
    .d     (bus.wr_ptr_gray),
    .q     (wr_gray_sync_s)
  );

  // Next read pointer and the level it leaves behind; a read into an empty FIFO is dropped.
  always_comb begin
    rd_fire_s      = bus.rd_en & ~empty_r;
    rd_bin_next_s  = rd_bin_r + {{ADD_SIZE{1'b0}}, rd_fire_s};
    rd_gray_next_s = PW'(bin2gray(MAX_W'(rd_bin_next_s), PW));
    wr_bin_s       = PW'(gray2bin(MAX_W'(wr_gray_sync_s), PW));
    level_next_s   = wr_bin_s - rd_bin_next_s;
    ovf_set_s      = (level_next_s > DEPTH_L);
  end

  // Read pointer and status registers; overflow set has priority over clear.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      rd_bin_r  <= {PW{1'b0}};
      rd_gray_r <= {PW{1'b0}};
      level_r   <= {PW{1'b0}};
      empty_r   <= 1'b1;
      ae_r      <= 1'b1;
      ovf_r     <= 1'b0;
    end else begin
      rd_bin_r  <= rd_bin_next_s;
      rd_gray_r <= rd_gray_next_s;
      level_r   <= level_next_s;
      empty_r   <= (rd_gray_next_s == wr_gray_sync_s);
      ae_r      <= (level_next_s <= AE_L);
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign bus.rd_addr         = rd_bin_r[ADD_SIZE-1:0];
  assign bus.rd_ptr_gray     = rd_gray_r;
  assign bus.wr_ptr_sync     = wr_bin_s;
  assign bus.rd_empty        = empty_r;
  assign bus.rd_almost_empty = ae_r;
  assign bus.rd_level        = level_r;
  assign bus.ovf_err         = ovf_r;

endmodule

// File: doc/rd_sync_ctrl.md
# rd_sync_ctrl

Read-domain control block for the asynchronous FIFO, succeeding the single-stage write-to-read pointer synchroniser. It carries the Gray-coded write pointer into `rd_clk` through a parametrised synchroniser chain, owns the read pointer, and derives the empty, almost-empty and fill-level status. It also raises a sticky overflow error. It sits between the write-domain pointer logic and the FIFO memory read port.

## Interface
- `ADD_SIZE`, 8: address bits; FIFO depth DEPTH = 2^ADD_SIZE; pointers are ADD_SIZE+1 bits.
- `SYNC_STAGES`, 2: synchroniser flops; legal range 2..4.
- `AE_LEVEL`, 4: almost-empty threshold in entries; legal range 0..DEPTH.

- `rd_clk`  in  1  read-domain clock; the only clock in the block.
- `rd_rst`  in  1  reset, asynchronous, active-low.
- `wr_ptr_gray`  in  ADD_SIZE+1  write pointer in Gray code, registered in the write domain.
- `rd_en`  in  1  read request.
- `err_clr`  in  1  clears `ovf_err`.
- `rd_addr`  out  ADD_SIZE  memory read address, equal to `rd_bin[ADD_SIZE-1:0]`.
- `rd_ptr_gray`  out  ADD_SIZE+1  registered Gray read pointer, sent to the write domain.
- `wr_ptr_sync`  out  ADD_SIZE+1  synchronised write pointer, converted to binary.
- `rd_empty`  out  1  FIFO empty, registered.
- `rd_almost_empty`  out  1  asserted when level ≤ `AE_LEVEL`, registered.
- `rd_level`  out  ADD_SIZE+1  entries available, registered.
- `ovf_err`  out  1  sticky: computed level exceeded DEPTH.

## Operation
- **Sync chain:** SYNC_STAGES × (ADD_SIZE+1) flops.
  - Stage 1 samples `wr_ptr_gray`; stage k samples stage k-1.
  - No logic is allowed between stages.
- **Binary write pointer:** `wr_ptr_sync` = gray2bin(last stage), combinational from the flop.
- **Read acceptance:** rd_fire = `rd_en` & !`rd_empty`.
  - A read while empty is ignored: no pointer change, no error.
- **Next read pointer:** rd_bin_next = rd_bin + rd_fire, modulo 2^(ADD_SIZE+1).
  - Wrap from all-ones to 0 toggles the MSB (lap bit).
- **Registers updated every `rd_clk` edge:**
  - rd_bin ← rd_bin_next
  - `rd_ptr_gray` ← bin2gray(rd_bin_next)
  - level_next = `wr_ptr_sync` − rd_bin_next, modulo 2^(ADD_SIZE+1)
  - `rd_empty` ← (bin2gray(rd_bin_next) == last sync stage)
  - `rd_level` ← level_next
  - `rd_almost_empty` ← (level_next ≤ AE_LEVEL)
- **Overflow error:** `ovf_err` is set when level_next > DEPTH and holds until `err_clr`.
  - If set and clear occur in the same cycle, set wins.
- Full detection belongs to the write-domain block; it is not generated here.

## Timing
- **Reset values** (asynchronous on `rd_rst`=0):
  - all sync stages 0, rd_bin 0, `rd_ptr_gray` 0, `wr_ptr_sync` 0, `rd_level` 0, `ovf_err` 0
  - `rd_empty` 1, `rd_almost_empty` 1
- Reset release is synchronous in effect; the first update occurs at the first `rd_clk` edge with `rd_rst`=1.
- **Write-pointer latency:** a change on `wr_ptr_gray` appears on `wr_ptr_sync` after SYNC_STAGES edges.
- **Status latency:** `rd_empty`, `rd_level` and `rd_almost_empty` reflect the change after SYNC_STAGES+1 edges.
- **Read latency:** a read accepted at edge t updates `rd_addr`, `rd_ptr_gray` and status at t.
  - The last read drives `rd_empty`=1 at that same edge.
- **Read with simultaneous sync update:** both the rd_bin_next term and the new sync value enter the same edge's computation.
- **Reset mid-operation:** all state returns immediately to reset values; no partial update is retained.
- **Burst writes:** the write pointer may advance by many entries between samples. The chain depends only on the Gray property that adjacent values differ in one bit, so no hamming-distance checks are made.

## Structure
- Package `fifo_sync_pkg`:
  - functions `bin2gray` and `gray2bin`, parametrised by width
  - the SYNC_STAGES legality check, as an elaboration-time assertion
- Sub-module `sync_chain`:
  - generic N-stage, W-bit flop chain, async active-low reset to 0
  - also reused for the read-to-write direction
- Top level holds the read pointer, level arithmetic and status registers.

## Test plan
- **Reset:** assert `rd_rst`=0 mid-traffic → all outputs at reset values in the same cycle; `rd_empty`=1, `rd_level`=0.
- **Latency:** SYNC_STAGES=2, `wr_ptr_gray` steps 0→1 → `wr_ptr_sync`=1 after 2 edges; `rd_empty`=0 and `rd_level`=1 after 3 edges.
- **Drain:** level 3, `rd_en` held high → `rd_addr` 0,1,2; `rd_empty`=1 on the third accepting edge; a fourth `rd_en` leaves `rd_addr`=3 and `rd_ptr_gray` unchanged.
- **Wrap:** ADD_SIZE=3, rd_bin at 15, write pointer at binary 1 → one read gives rd_bin=0 and `rd_ptr_gray`=0; `rd_level`=1.
- **Almost-empty:** AE_LEVEL=4, level 5 → 4 via a read → `rd_almost_empty` rises on that edge; rd_bin 0 with write pointer binary 5 → `rd_almost_empty`=0.
- **Overflow:** drive `wr_ptr_gray`=bin2gray(DEPTH+1) with rd_bin 0 → `ovf_err`=1 and held; `err_clr` pulse → 0; set and clear together → stays 1.
